// File: rtl/craps_multi_ctrl_if.sv
// Roll-button / dice-sum / result bundle between the game controller and its front end.
// The master drives the button, sum and ack; the slave (controller) drives the results.
interface craps_multi_ctrl_if #(
   parameter int unsigned SUM_W       = 4,
   parameter int unsigned NUM_PLAYERS = 2,
   parameter int unsigned PLAYER_W    = 1,
   parameter int unsigned SCORE_W     = 8
);
   logic                           rb;
   logic [SUM_W-1:0]               sum;
   logic                           ack;
   logic                           roll;
   logic                           win;
   logic                           lose;
   logic                           bad_sum;
   logic [PLAYER_W-1:0]            player;
   logic [SUM_W-1:0]               point;
   logic [NUM_PLAYERS*SCORE_W-1:0] scores;

   modport master (
      output rb, sum, ack,
      input  roll, win, lose, bad_sum, player, point, scores
   );

   modport slave (
      input  rb, sum, ack,
      output roll, win, lose, bad_sum, player, point, scores
   );
endinterface

// File: rtl/craps_multi_ctrl.sv
// Craps first-roll / point-roll controller with rotating shooters, saturating per-player
// win counters, a point-phase roll limit and illegal-sum rejection.
module craps_multi_ctrl #(
   parameter int unsigned SUM_W        = 4,
   parameter int unsigned NUM_PLAYERS  = 2,
   parameter int unsigned PLAYER_W     = 1,
   parameter int unsigned SCORE_W      = 8,
   parameter int unsigned MAX_PT_ROLLS = 15
) (
   input logic                clk_i,
   input logic                rst_i,
   craps_multi_ctrl_if.slave  bus
);
   localparam int unsigned CntW = (MAX_PT_ROLLS == 0) ? 1 : $clog2(MAX_PT_ROLLS + 1);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StRoll1 = 3'd1,
      StPwait = 3'd2,
      StRoll2 = 3'd3,
      StWin   = 3'd4,
      StLose  = 3'd5
   } state_e;

   state_e                         state_q, state_d;
   logic [PLAYER_W-1:0]            player_q, player_d;
   logic [SUM_W-1:0]               point_q, point_d;
   logic [CntW-1:0]                cnt_q, cnt_d;
   logic [NUM_PLAYERS*SCORE_W-1:0] scores_q, scores_d;
   logic                           bad_sum_q, bad_sum_d;
   logic                           roll, win, lose, win_entry;
   logic                           sum_legal, sum_natural, sum_craps;
   logic [CntW-1:0]                cnt_inc;

   assign sum_legal   = (bus.sum >= SUM_W'(2)) && (bus.sum <= SUM_W'(12));
   assign sum_natural = (bus.sum == SUM_W'(7)) || (bus.sum == SUM_W'(11));
   assign sum_craps   = (bus.sum == SUM_W'(2)) || (bus.sum == SUM_W'(3)) ||
                        (bus.sum == SUM_W'(12));
   assign cnt_inc     = cnt_q + CntW'(1);

   always_comb begin
      state_d   = state_q;
      player_d  = player_q;
      point_d   = point_q;
      cnt_d     = cnt_q;
      scores_d  = scores_q;
      bad_sum_d = 1'b0;
      roll      = 1'b0;
      win       = 1'b0;
      lose      = 1'b0;
      win_entry = 1'b0;

      case (state_q)
         StIdle: begin
            if (bus.rb) state_d = StRoll1;
         end
         StRoll1: begin
            roll = bus.rb;
            if (!bus.rb) begin
               if (!sum_legal) begin
                  bad_sum_d = 1'b1;
               end else if (sum_natural) begin
                  state_d   = StWin;
                  win_entry = 1'b1;
               end else if (sum_craps) begin
                  state_d = StLose;
               end else begin
                  point_d = bus.sum;
                  cnt_d   = '0;
                  state_d = StPwait;
               end
            end
         end
         StPwait: begin
            if (bus.rb) state_d = StRoll2;
         end
         StRoll2: begin
            roll = bus.rb;
            if (!bus.rb) begin
               if (!sum_legal) begin
                  bad_sum_d = 1'b1;
               end else if (bus.sum == point_q) begin
                  state_d   = StWin;
                  win_entry = 1'b1;
               end else if (bus.sum == SUM_W'(7)) begin
                  state_d = StLose;
               end else begin
                  cnt_d = cnt_inc;
                  // A zero limit means the point phase may run forever.
                  if ((MAX_PT_ROLLS != 0) && (cnt_inc == CntW'(MAX_PT_ROLLS))) begin
                     state_d = StLose;
                  end else begin
                     state_d = StPwait;
                  end
               end
            end
         end
         StWin: begin
            win = 1'b1;
            if (bus.ack) begin
               state_d = StIdle;
               point_d = '0;
            end
         end
         StLose: begin
            lose = 1'b1;
            if (bus.ack) begin
               state_d  = StIdle;
               point_d  = '0;
               player_d = (player_q == PLAYER_W'(NUM_PLAYERS - 1)) ? '0
                                                                   : player_q + PLAYER_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      for (int k = 0; k < NUM_PLAYERS; k++) begin
         if (win_entry && (player_q == PLAYER_W'(k)) &&
             (scores_q[k*SCORE_W +: SCORE_W] != {SCORE_W{1'b1}})) begin
            scores_d[k*SCORE_W +: SCORE_W] = scores_q[k*SCORE_W +: SCORE_W] + SCORE_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         player_q  <= '0;
         point_q   <= '0;
         cnt_q     <= '0;
         scores_q  <= '0;
         bad_sum_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         player_q  <= player_d;
         point_q   <= point_d;
         cnt_q     <= cnt_d;
         scores_q  <= scores_d;
         bad_sum_q <= bad_sum_d;
      end
   end

   assign bus.roll    = roll;
   assign bus.win     = win;
   assign bus.lose    = lose;
   assign bus.bad_sum = bad_sum_q;
   assign bus.player  = player_q;
   assign bus.point   = point_q;
   assign bus.scores  = scores_q;
endmodule

// File: tb/tb_craps_multi_ctrl.sv
// Bench for craps_multi_ctrl: three configurations (limit 15, limit 3 with 2-bit scores,
// unlimited) share one stimulus stream; table vectors plus hand-written corner sequences.
module tb_craps_multi_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rb  = 1'b0;
   logic [3:0] sum = '0;
   logic       ack = 1'b0;

   int checks = 0;
   int errors = 0;

   craps_multi_ctrl_if #(.SCORE_W(8)) ia ();
   craps_multi_ctrl_if #(.SCORE_W(2)) ib ();
   craps_multi_ctrl_if #(.SCORE_W(8)) ic ();

   assign ia.rb = rb;  assign ia.sum = sum;  assign ia.ack = ack;
   assign ib.rb = rb;  assign ib.sum = sum;  assign ib.ack = ack;
   assign ic.rb = rb;  assign ic.sum = sum;  assign ic.ack = ack;

   craps_multi_ctrl #(.SCORE_W(8), .MAX_PT_ROLLS(15)) u_a (.clk_i(clk), .rst_i(rst), .bus(ia));
   craps_multi_ctrl #(.SCORE_W(2), .MAX_PT_ROLLS(3))  u_b (.clk_i(clk), .rst_i(rst), .bus(ib));
   craps_multi_ctrl #(.SCORE_W(8), .MAX_PT_ROLLS(0))  u_c (.clk_i(clk), .rst_i(rst), .bus(ic));

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rb;
      logic [3:0] sum;
      logic       ack;
      logic       win;
      logic       lose;
      logic       bad;
      logic       roll;
      logic [3:0] point;
      logic       player;
      logic [7:0] s0;
      logic [7:0] s1;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   function automatic vec_t v(logic r, logic [3:0] s, logic a, logic w, logic l, logic b,
                              logic ro, logic [3:0] pt, logic pl, logic [7:0] s0,
                              logic [7:0] s1);
      vec_t x;
      x = '{rb: r, sum: s, ack: a, win: w, lose: l, bad: b, roll: ro, point: pt, player: pl,
            s0: s0, s1: s1};
      return x;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [3:0] s, input logic a);
      @(negedge clk);
      rb  = r;
      sum = s;
      ack = a;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      rb  = 1'b0;
      sum = '0;
      ack = 1'b0;
      #3 rst = 1'b0;
   endtask

   function automatic logic [27:0] obs_a();
      return {ia.win, ia.lose, ia.bad_sum, ia.roll, ia.point, ia.player, ia.scores[7:0],
              ia.scores[15:8]};
   endfunction

   initial begin
      vec_t e;
      logic [3:0] pt_sums [5];
      pt_sums[0] = 4'd6; pt_sums[1] = 4'd8; pt_sums[2] = 4'd9;
      pt_sums[3] = 4'd4; pt_sums[4] = 4'd10;

      //                 rb sum ack  win lose bad roll pt pl s0 s1
      tbl.push_back(v(1, 0,  0, 0, 0, 0, 1, 0,  0, 0, 0));
      tbl.push_back(v(1, 0,  0, 0, 0, 0, 1, 0,  0, 0, 0));
      tbl.push_back(v(1, 0,  0, 0, 0, 0, 1, 0,  0, 0, 0));
      tbl.push_back(v(0, 7,  0, 1, 0, 0, 0, 0,  0, 1, 0));
      tbl.push_back(v(0, 0,  1, 0, 0, 0, 0, 0,  0, 1, 0));
      tbl.push_back(v(0, 0,  1, 0, 0, 0, 0, 0,  0, 1, 0));
      tbl.push_back(v(1, 0,  0, 0, 0, 0, 1, 0,  0, 1, 0));
      tbl.push_back(v(0, 3,  0, 0, 1, 0, 0, 0,  0, 1, 0));
      tbl.push_back(v(0, 0,  1, 0, 0, 0, 0, 0,  1, 1, 0));
      tbl.push_back(v(1, 0,  0, 0, 0, 0, 1, 0,  1, 1, 0));
      tbl.push_back(v(0, 12, 0, 0, 1, 0, 0, 0,  1, 1, 0));
      tbl.push_back(v(0, 0,  1, 0, 0, 0, 0, 0,  0, 1, 0));
      tbl.push_back(v(1, 0,  0, 0, 0, 0, 1, 0,  0, 1, 0));
      tbl.push_back(v(0, 4,  0, 0, 0, 0, 0, 4,  0, 1, 0));
      tbl.push_back(v(1, 0,  0, 0, 0, 0, 1, 4,  0, 1, 0));
      tbl.push_back(v(0, 6,  0, 0, 0, 0, 0, 4,  0, 1, 0));
      tbl.push_back(v(1, 0,  0, 0, 0, 0, 1, 4,  0, 1, 0));
      tbl.push_back(v(0, 8,  0, 0, 0, 0, 0, 4,  0, 1, 0));
      tbl.push_back(v(1, 0,  0, 0, 0, 0, 1, 4,  0, 1, 0));
      tbl.push_back(v(0, 4,  0, 1, 0, 0, 0, 4,  0, 2, 0));
      tbl.push_back(v(1, 0,  1, 0, 0, 0, 0, 0,  0, 2, 0));
      tbl.push_back(v(1, 0,  0, 0, 0, 0, 1, 0,  0, 2, 0));
      tbl.push_back(v(0, 4,  0, 0, 0, 0, 0, 4,  0, 2, 0));
      tbl.push_back(v(1, 0,  0, 0, 0, 0, 1, 4,  0, 2, 0));
      tbl.push_back(v(0, 6,  0, 0, 0, 0, 0, 4,  0, 2, 0));
      tbl.push_back(v(1, 0,  0, 0, 0, 0, 1, 4,  0, 2, 0));
      tbl.push_back(v(0, 7,  0, 0, 1, 0, 0, 4,  0, 2, 0));
      tbl.push_back(v(0, 0,  1, 0, 0, 0, 0, 0,  1, 2, 0));
      tbl.push_back(v(1, 0,  0, 0, 0, 0, 1, 0,  1, 2, 0));
      tbl.push_back(v(0, 13, 0, 0, 0, 1, 0, 0,  1, 2, 0));
      tbl.push_back(v(1, 1,  0, 0, 0, 0, 1, 0,  1, 2, 0));
      tbl.push_back(v(0, 1,  0, 0, 0, 1, 0, 0,  1, 2, 0));
      tbl.push_back(v(1, 0,  0, 0, 0, 0, 1, 0,  1, 2, 0));
      tbl.push_back(v(0, 10, 0, 0, 0, 0, 0, 10, 1, 2, 0));
      tbl.push_back(v(1, 0,  0, 0, 0, 0, 1, 10, 1, 2, 0));
      tbl.push_back(v(0, 13, 0, 0, 0, 1, 0, 10, 1, 2, 0));
      tbl.push_back(v(1, 0,  0, 0, 0, 0, 1, 10, 1, 2, 0));
      tbl.push_back(v(0, 0,  0, 0, 0, 1, 0, 10, 1, 2, 0));
      tbl.push_back(v(1, 0,  0, 0, 0, 0, 1, 10, 1, 2, 0));
      tbl.push_back(v(0, 10, 0, 1, 0, 0, 0, 10, 1, 2, 1));
      tbl.push_back(v(0, 0,  1, 0, 0, 0, 0, 0,  1, 2, 1));

      do_reset();
      chk("reset_a", {36'd0, obs_a()}, 64'd0);
      chk("reset_b", {ib.win, ib.lose, ib.bad_sum, ib.roll, ib.point, ib.player, ib.scores},
          64'd0);

      // Table vectors: expected pushed when driven, popped once the edge has landed.
      for (int i = 0; i < tbl.size(); i++) begin
         exp_q.push_back(tbl[i]);
         step(tbl[i].rb, tbl[i].sum, tbl[i].ack);
         e = exp_q.pop_front();
         chk($sformatf("vec%0d", i), {36'd0, obs_a()},
             {36'd0, e.win, e.lose, e.bad, e.roll, e.point, e.player, e.s0, e.s1});
      end

      // Point 5, then 20 non-deciding rolls: limit 3 loses on the 3rd, limit 15 on the
      // 15th, unlimited keeps playing.
      do_reset();
      step(1, 0, 0);
      step(0, 5, 0);
      for (int i = 1; i <= 20; i++) begin
         step(1, 0, 0);
         step(0, pt_sums[i % 5], 0);
         chk($sformatf("limit15_r%0d", i), {63'd0, ia.lose}, {63'd0, (i >= 15)});
         chk($sformatf("limit3_r%0d", i), {63'd0, ib.lose}, {63'd0, (i >= 3)});
         chk($sformatf("unlim_r%0d", i), {62'd0, ic.win, ic.lose}, 64'd0);
      end
      chk("unlim_point", {60'd0, ic.point}, 64'd5);

      // Saturating 2-bit score vs 8-bit score over five straight wins.
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         step(1, 0, 0);
         step(0, (i % 2 == 0) ? 4'd11 : 4'd7, 0);
         step(0, 0, 1);
         chk($sformatf("sat2_w%0d", i), {62'd0, ib.scores[1:0]}, (i > 3) ? 64'd3 : 64'(i));
         chk($sformatf("sat8_w%0d", i), {56'd0, ia.scores[7:0]}, 64'(i));
      end
      chk("sat_player", {63'd0, ib.player}, 64'd0);

      // Asynchronous reset landing mid-cycle, first in ROLL2, then in WIN.
      do_reset();
      step(1, 0, 0);
      step(0, 7, 0);
      step(0, 0, 1);
      step(1, 0, 0);
      step(0, 2, 0);
      step(0, 0, 1);
      step(1, 0, 0);
      step(0, 6, 0);
      step(1, 0, 0);
      chk("pre_rst_roll2", {36'd0, obs_a()}, {36'd0, 4'b0001, 4'd6, 1'b1, 8'd1, 8'd0});
      #2 rst = 1'b1;
      #1 chk("async_rst_roll2", {36'd0, obs_a()}, 64'd0);
      #3 rst = 1'b0;
      step(1, 0, 0);
      step(0, 11, 0);
      chk("pre_rst_win", {36'd0, obs_a()}, {36'd0, 4'b1000, 4'd0, 1'b0, 8'd1, 8'd0});
      #2 rst = 1'b1;
      #1 chk("async_rst_win", {36'd0, obs_a()}, 64'd0);
      #3 rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
